// File: rtl/usb_tx_serializer.sv
// usb_tx_serializer: full-speed USB transmitter (SYNC, LSB-first data, bit stuffing, NRZI, EOP)
module usb_tx_serializer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk_48,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_strobe,
    output logic       busy,
    output logic       tx_en,
    output logic       tx_j,
    output logic       tx_se0
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP_SE0, EOP_J} state_t;
    state_t state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0] bit_idx, bit_idx_n, ones, ones_n, ones_inc;
    logic [7:0] shreg, shreg_n;
    logic line, line_n, stuff, stuff_n;
    logic bit_end, sending, cur_bit, need_stuff, boundary, next_bit;
    always_comb begin
        bit_end = timer == TW'(CLKS_PER_BIT - 1);
        sending = state == SYNC || state == DATA;
        cur_bit = stuff ? 1'b0 : shreg[0];
        ones_inc = cur_bit ? ones + 3'd1 : 3'd0;
        need_stuff = ones_inc == 3'd6;
        boundary = stuff ? bit_idx == 3'd0 : bit_idx == 3'd7;
        next_bit = stuff ? shreg[0] : shreg[1];
        state_n = state;
        timer_n = (state == IDLE || bit_end) ? '0 : timer + TW'(1);
        bit_idx_n = bit_idx;
        ones_n = ones;
        shreg_n = shreg;
        line_n = line;
        stuff_n = stuff;
        data_strobe = 1'b0;
        tx_en = state != IDLE;
        busy = tx_en;
        tx_se0 = state == EOP_SE0;
        tx_j = sending ? line : 1'b1;
        if (state == IDLE) begin
            if (tx_start) begin
                state_n = SYNC;
                shreg_n = 8'h80;
                bit_idx_n = 3'd0;
                ones_n = 3'd0;
                stuff_n = 1'b0;
                line_n = 1'b0;
            end
        end else if (sending && bit_end) begin
            ones_n = ones_inc;
            if (need_stuff) begin
                stuff_n = 1'b1;
                line_n = ~line;
                shreg_n = shreg >> 1;
                bit_idx_n = bit_idx + 3'd1;
            end else if (boundary) begin
                stuff_n = 1'b0;
                bit_idx_n = 3'd0;
                if (data_in_valid) begin
                    data_strobe = 1'b1;
                    state_n = DATA;
                    shreg_n = data_in;
                    line_n = data_in[0] ? line : ~line;
                end else begin
                    state_n = EOP_SE0;
                end
            end else begin
                stuff_n = 1'b0;
                line_n = next_bit ? line : ~line;
                if (!stuff) begin
                    shreg_n = shreg >> 1;
                    bit_idx_n = bit_idx + 3'd1;
                end
            end
        end else if (state == EOP_SE0 && bit_end) begin
            bit_idx_n = bit_idx + 3'd1;
            state_n = bit_idx == 3'd1 ? EOP_J : EOP_SE0;
        end else if (state == EOP_J && bit_end) begin
            state_n = IDLE;
        end
    end
    always_ff @(posedge clk_48) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
            bit_idx <= 3'd0;
            ones <= 3'd0;
            shreg <= 8'h00;
            line <= 1'b1;
            stuff <= 1'b0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            bit_idx <= bit_idx_n;
            ones <= ones_n;
            shreg <= shreg_n;
            line <= line_n;
            stuff <= stuff_n;
        end
    end
endmodule

// File: tb/tb_usb_tx_serializer.sv
// tb_usb_tx_serializer: scoreboard bench comparing line states against a bit-level packet model
module tb_usb_tx_serializer;
    localparam int CPB = 4;
    logic clk_48 = 1'b0;
    logic rst_n = 1'b0;
    logic tx_start = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic data_in_valid = 1'b0;
    logic data_strobe, busy, tx_en, tx_j, tx_se0;
    int checks = 0;
    int failures = 0;
    typedef struct packed {logic j; logic se0; logic strobe;} exp_t;
    exp_t exp_q[$];
    int len_q[$];
    logic [7:0] pkt[$];
    logic rst_sampled = 1'b0;

    usb_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
        .clk_48(clk_48),
        .rst_n(rst_n),
        .tx_start(tx_start),
        .data_in(data_in),
        .data_in_valid(data_in_valid),
        .data_strobe(data_strobe),
        .busy(busy),
        .tx_en(tx_en),
        .tx_j(tx_j),
        .tx_se0(tx_se0)
    );

    always #5 clk_48 = ~clk_48;
    always @(posedge clk_48) rst_sampled <= !rst_n;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic j, input logic se0, input logic s);
        exp_t e;
        e.j = j;
        e.se0 = se0;
        e.strobe = s;
        return e;
    endfunction

    // Bit slots: SYNC, then data bits with a 0 inserted after every six consecutive 1s
    task automatic push_model();
        logic bits[$];
        logic strb[$];
        int ones;
        int n;
        logic lvl;
        for (int i = 0; i < 8; i++) begin
            bits.push_back(i == 7);
            strb.push_back(1'b0);
        end
        ones = 1;
        foreach (pkt[k]) begin
            strb[strb.size() - 1] = 1'b1;
            for (int i = 0; i < 8; i++) begin
                bits.push_back(pkt[k][i]);
                strb.push_back(1'b0);
                ones = pkt[k][i] ? ones + 1 : 0;
                if (ones == 6) begin
                    bits.push_back(1'b0);
                    strb.push_back(1'b0);
                    ones = 0;
                end
            end
        end
        lvl = 1'b1;
        n = 0;
        foreach (bits[s]) begin
            lvl = bits[s] ? lvl : ~lvl;
            for (int c = 0; c < CPB; c++) begin
                exp_q.push_back(mk(lvl, 1'b0, strb[s] && c == CPB - 1));
                n++;
            end
        end
        for (int c = 0; c < 2 * CPB; c++) exp_q.push_back(mk(1'b1, 1'b1, 1'b0));
        for (int c = 0; c < CPB; c++) exp_q.push_back(mk(1'b1, 1'b0, 1'b0));
        len_q.push_back(n + 3 * CPB);
    endtask

    task automatic run_pkt(input int extra_at, input int reset_at);
        int idx;
        int nstrobe;
        logic s;
        bit done;
        idx = 0;
        nstrobe = 0;
        done = 0;
        push_model();
        data_in = pkt.size() > 0 ? pkt[0] : 8'h00;
        data_in_valid = pkt.size() > 0;
        tx_start = 1'b1;
        @(posedge clk_48);
        #1;
        tx_start = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk_48);
            if (cyc == 0) check("start_latency", int'({busy, tx_en, tx_j}), 6);
            s = data_strobe;
            @(posedge clk_48);
            #1;
            tx_start = cyc == extra_at;
            if (s) begin
                nstrobe++;
                idx++;
                data_in = idx < pkt.size() ? pkt[idx] : 8'($urandom);
                data_in_valid = idx < pkt.size();
            end
            if (cyc == reset_at) begin
                rst_n = 1'b0;
                data_in_valid = 1'b0;
                exp_q.delete();
                len_q.delete();
                repeat (2) begin
                    @(posedge clk_48);
                    #1;
                end
                rst_n = 1'b1;
                return;
            end
            if (!busy) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL pkt_timeout actual=busy_stuck required=busy_low at %0t", $time);
        end
        check("strobe_count", nstrobe, pkt.size());
    endtask

    task automatic rand_pkt(input int n);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back($urandom_range(0, 2) == 0 ? 8'hFF : 8'($urandom));
    endtask

    initial begin : monitor
        exp_t e;
        int cur_len;
        logic prev_en;
        cur_len = 0;
        prev_en = 1'b0;
        forever begin
            @(negedge clk_48);
            if (!rst_n && !rst_sampled) begin
                prev_en = 1'b0;
                cur_len = 0;
                continue;
            end
            if (tx_en && !rst_sampled) begin
                cur_len++;
                check("busy_vs_en", int'(busy), 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_tx actual=tx_en_high required=idle at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_j", int'(tx_j), int'(e.j));
                    check("tx_se0", int'(tx_se0), int'(e.se0));
                    check("data_strobe", int'(data_strobe), int'(e.strobe));
                end
            end else begin
                check("idle_out", int'({tx_en, tx_j, tx_se0, data_strobe, busy}), 8);
                if (prev_en) begin
                    if (len_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL pkt_len actual=%0d required=none at %0t", cur_len, $time);
                    end else begin
                        check("pkt_len", cur_len, len_q.pop_front());
                    end
                end
                cur_len = 0;
            end
            prev_en = tx_en && !rst_sampled;
        end
    end

    initial begin : stim
        repeat (3) @(posedge clk_48);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk_48);
        #1;
        pkt = '{8'hD2};
        run_pkt(-1, -1);
        repeat (5) @(posedge clk_48);
        #1;
        pkt = '{8'hC3, 8'hFF, 8'hFF};
        run_pkt(-1, -1);
        repeat (5) @(posedge clk_48);
        #1;
        pkt.delete();
        run_pkt(-1, -1);
        repeat (5) @(posedge clk_48);
        #1;
        rand_pkt(2);
        run_pkt(40, -1);
        rand_pkt(1);
        run_pkt(-1, -1);
        rand_pkt(2);
        run_pkt(-1, -1);
        repeat (4) @(posedge clk_48);
        #1;
        rand_pkt(3);
        run_pkt(-1, 8 * CPB + 8 * CPB + 12);
        repeat (4) @(posedge clk_48);
        #1;
        rand_pkt(2);
        run_pkt(-1, -1);
        for (int p = 0; p < 15; p++) begin
            repeat ($urandom_range(0, 6)) @(posedge clk_48);
            #1;
            rand_pkt($urandom_range(0, 4));
            run_pkt($urandom_range(0, 1) == 1 ? int'($urandom_range(5, 60)) : -1, -1);
        end
        repeat (10) @(posedge clk_48);
        #1;
        check("leftover_exp", exp_q.size(), 0);
        check("leftover_len", len_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/usb_tx_serializer.md
# usb_tx_serializer

Full-speed USB packet transmitter for the device-side USB core. It takes a byte stream from the protocol layer and serialises it onto the bus: SYNC, LSB-first data, bit stuffing, NRZI encoding and EOP. Its outputs drive the `tx_j`/`tx_se0`/`tx_en` pad logic directly. It is the transmit counterpart of the core's `rx_j`/`rx_se0` receive path and runs on the 48 MHz USB clock.

## Interface
- `CLKS_PER_BIT`, 4: clocks per bus bit (12 Mbit/s at 48 MHz). Legal values are 2 and above.
- `clk_48`  in  1  48 MHz USB clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `tx_start`  in  1  single-cycle request to send one packet; ignored while `busy`=1.
- `data_in`  in  8  next packet byte (PID first); must be stable while `data_in_valid`=1.
- `data_in_valid`  in  1  high while another byte remains to be sent; low means end of packet.
- `data_strobe`  out  1  one-cycle pulse on the edge that `data_in` is latched; upstream advances afterwards.
- `busy`  out  1  high from the cycle after an accepted `tx_start` until the cycle `tx_en` falls.
- `tx_en`  out  1  output-enable for D+/D-.
- `tx_j`  out  1  differential line state: 1 = J (D+ high), 0 = K.
- `tx_se0`  out  1  drive single-ended zero (overrides `tx_j`).

## Operation
- States: IDLE, SYNC, DATA, EOP_SE0, EOP_J.
- Bit timer: counts 0..CLKS_PER_BIT-1. A bit ends when the counter reaches CLKS_PER_BIT-1. Every state change and shift happens only at a bit end.
- IDLE:
  - Outputs `tx_en`=0, `tx_j`=1, `tx_se0`=0, `busy`=0.
  - `tx_start`=1 moves to SYNC. The line state register is preset to J, the ones counter is 0 and the bit timer is 0.
- SYNC:
  - Sends 8'h80 LSB-first through the NRZI encoder, giving K J K J K J K K.
  - The ones counter ends SYNC at 1.
- NRZI: a 0 bit toggles the line state; a 1 bit holds it.
- Bit stuffing, which applies after SYNC:
  - Each transmitted 1 increments the ones counter; each 0 clears it.
  - When the counter reaches 6, the next bit slot is a stuffed 0 (toggle, counter cleared) before the next data bit.
  - Stuffing also applies after the last bit of the last byte, before EOP.
- Byte loading:
  - At the end of SYNC's last bit, and at the end of each byte's last bit (including any trailing stuff bit), `data_in_valid` is sampled.
  - If it is 1, `data_in` is loaded into the shift register, `data_strobe` pulses in that same cycle, and the state is DATA.
  - If it is 0, the state moves to EOP_SE0 and no strobe is issued.
- EOP_SE0: `tx_se0`=1 and `tx_j`=1 for 2 bit times.
- EOP_J: `tx_se0`=0 and `tx_j`=1 for 1 bit time. The block then returns to IDLE, dropping `tx_en` and `busy` on the same edge.
- Width rules: ones counter 3 bits, bit index 3 bits, bit timer clog2(CLKS_PER_BIT) bits. None of these may wrap mid-packet.
- `tx_start` during `busy` is ignored, with no queuing. Inter-packet gap is the caller's responsibility.
- Reset mid-packet: the next edge forces the IDLE outputs and clears all counters. The packet is truncated with no EOP.

## Timing
- Reset values: `tx_en`=0, `tx_j`=1, `tx_se0`=0, `data_strobe`=0, `busy`=0.
- `tx_start` sampled at edge N:
  - `tx_en`=1, `busy`=1 and `tx_j`=0 (first SYNC K) from cycle N+1.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
- First `data_strobe` occurs at cycle N+8·CLKS_PER_BIT. The first PID bit is driven on the following cycle.
- Cycles with `tx_en`=1 per packet: (8 + 8·bytes + stuffed_bits + 3)·CLKS_PER_BIT.
- `data_strobe` is never high for more than one cycle. Strobes are at least 8·CLKS_PER_BIT cycles apart.

## Test plan
- **Reset:** `rst_n`=0 for 3 cycles, then idle 10 cycles → `tx_en`=0, `tx_j`=1, `tx_se0`=0, `busy`=0, `data_strobe`=0 throughout.
- **ACK** (single byte 0xD2, `data_in_valid` dropped after the strobe):
  - `tx_j` per bit is SYNC 0,1,0,1,0,1,0,0, then PID 1,1,0,1,1,0,0,0.
  - Then SE0 for 8 cycles and J for 4 cycles.
  - `tx_en` is high for 76 cycles, with exactly 1 strobe.
- **Stuffing** (bytes 0xC3, 0xFF, 0xFF):
  - Stuff bits appear after FF#1 bit 3, after FF#2 bit 1, and after FF#2 bit 7, before EOP.
  - `tx_en` is high for 152 cycles, with 3 strobes.
- **Empty** (`tx_start` with `data_in_valid`=0): SYNC then EOP, `tx_en` high for 44 cycles, no strobe.
- **Busy / back-to-back:**
  - A second `tx_start` pulse mid-packet is ignored: only one SYNC and an unchanged cycle count.
  - A `tx_start` in the cycle after `busy` falls starts a new SYNC on the next cycle.
- **Reset mid-packet** (`rst_n`=0 during the second data byte): outputs reach idle values on the next edge, with no SE0 driven. A subsequent `tx_start` transmits normally.
